// File: rtl/vga_fb_pkg.sv
// Shared types and constants for the UART-fed VGA frame buffer: receiver states,
// command byte codes and a packed-pixel channel extractor.
package vga_fb_pkg;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_state_e;

  localparam logic [7:0] CMD_HOME    = 8'h80;
  localparam logic [7:0] CMD_CLEAR   = 8'h81;
  localparam logic [7:0] CMD_PATTERN = 8'h82;
  localparam logic [7:0] CMD_ROWUP   = 8'h83;

  // Channel idx 0 = blue (LSBs), 1 = green, 2 = red (MSBs) of a packed pixel
  function automatic logic [6:0] pix_field(input logic [6:0]  pix,
                                           input int unsigned col_w,
                                           input int unsigned idx);
    logic [6:0] mask;
    mask = 7'((1 << col_w) - 1);
    return (pix >> (idx * col_w)) & mask;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, start-glitch rejection, mid-bit sampling,
// framing-error drop, one-cycle valid strobe after a good stop bit.
module uart_rx
  import vga_fb_pkg::*;
#(
  parameter int unsigned ClksPerBit = 12
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       vld_o
);

  localparam int unsigned CntW = $clog2(ClksPerBit);
  localparam logic [CntW-1:0] CntHalf = CntW'(ClksPerBit / 2 - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(ClksPerBit - 1);

  uart_state_e     state_q, state_d;
  logic [2:0]      sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            vld_q, vld_d;
  logic            rx_s, rx_p;

  assign rx_s = sync_q[1];
  assign rx_p = sync_q[2];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      sync_q  <= 3'b111;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[1:0], rx_i};
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    vld_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s && rx_p) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == CntFull) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (cnt_q == CntFull) begin
          cnt_d   = '0;
          vld_d   = rx_s;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    byte_o = shift_q;
    vld_o  = vld_q;
  end

endmodule

// File: rtl/vga_fb_uart.sv
// UART-written cell frame buffer scanned by a VGA raster generator; outputs are registered,
// two cycles behind the counters. Define TEST_PATTERN_EN to add the 0x82 colour-bar mode.
module vga_fb_uart
  import vga_fb_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 12,
  parameter int unsigned COL_W        = 2,
  parameter int unsigned H_VIS        = 320,
  parameter int unsigned H_FP         = 8,
  parameter int unsigned H_SYNC       = 48,
  parameter int unsigned H_BP         = 24,
  parameter int unsigned V_VIS        = 240,
  parameter int unsigned V_FP         = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BP         = 33,
  parameter int unsigned SCALE_SH     = 3,
  parameter int unsigned FB_W         = 40,
  parameter int unsigned FB_H         = 30
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_rx,
  output logic             o_hs,
  output logic             o_vs,
  output logic [COL_W-1:0] o_r,
  output logic [COL_W-1:0] o_g,
  output logic [COL_W-1:0] o_b
);

  localparam int unsigned PIX_W    = 3 * COL_W;
  localparam int unsigned FB_DEPTH = FB_W * FB_H;
  localparam int unsigned ADDR_W   = $clog2(FB_DEPTH);
  localparam int unsigned H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_CW     = $clog2(H_TOT);
  localparam int unsigned V_CW     = $clog2(V_TOT);

  localparam logic [H_CW-1:0]   H_LAST    = H_CW'(H_TOT - 1);
  localparam logic [H_CW-1:0]   H_VIS_C   = H_CW'(H_VIS);
  localparam logic [H_CW-1:0]   HS_BEG    = H_CW'(H_VIS + H_FP);
  localparam logic [H_CW-1:0]   HS_END    = H_CW'(H_VIS + H_FP + H_SYNC);
  localparam logic [V_CW-1:0]   V_LAST    = V_CW'(V_TOT - 1);
  localparam logic [V_CW-1:0]   V_VIS_C   = V_CW'(V_VIS);
  localparam logic [V_CW-1:0]   VS_BEG    = V_CW'(V_VIS + V_FP);
  localparam logic [V_CW-1:0]   VS_END    = V_CW'(V_VIS + V_FP + V_SYNC);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(FB_W);
  localparam logic [ADDR_W-1:0] ROW_WRAP  = ADDR_W'(FB_DEPTH - FB_W);

  logic [7:0]        rx_byte;
  logic              rx_vld;
  logic [ADDR_W-1:0] wptr_q, wptr_d, clr_addr_q, clr_addr_d, waddr, rd_addr;
  logic              clr_q, clr_d, we;
  logic [PIX_W-1:0]  wdata, rd_q, pix;
  logic [PIX_W-1:0]  mem [FB_DEPTH];
  logic [H_CW-1:0]   h_q, h_d;
  logic [V_CW-1:0]   v_q, v_d;
  logic              vis, hs1_q, vs1_q, vis1_q;
`ifdef TEST_PATTERN_EN
  logic              pat_q, pat_d;
  logic [2:0]        bars1_q;
`endif

  uart_rx #(
    .ClksPerBit(CLKS_PER_BIT)
  ) u_uart_rx (
    .clk_i (i_clk),
    .rst_ni(i_nrst),
    .rx_i  (i_rx),
    .byte_o(rx_byte),
    .vld_o (rx_vld)
  );

  // Clear owns the write port; bytes arriving meanwhile are discarded.
  always_comb begin
    wptr_d     = wptr_q;
    clr_d      = clr_q;
    clr_addr_d = clr_addr_q;
    we         = 1'b0;
    waddr      = wptr_q;
    wdata      = '0;
`ifdef TEST_PATTERN_EN
    pat_d      = pat_q;
`endif
    if (clr_q) begin
      we         = 1'b1;
      waddr      = clr_addr_q;
      clr_addr_d = clr_addr_q + ADDR_W'(1);
      if (clr_addr_q == LAST_ADDR) begin
        clr_d      = 1'b0;
        clr_addr_d = '0;
        wptr_d     = '0;
      end
    end else if (rx_vld) begin
      if (!rx_byte[7]) begin
        we     = 1'b1;
        wdata  = rx_byte[PIX_W-1:0];
        wptr_d = (wptr_q == LAST_ADDR) ? '0 : wptr_q + ADDR_W'(1);
      end else begin
        case (rx_byte)
          CMD_HOME:  wptr_d = '0;
          CMD_CLEAR: begin
            clr_d      = 1'b1;
            clr_addr_d = '0;
          end
`ifdef TEST_PATTERN_EN
          CMD_PATTERN: pat_d = ~pat_q;
`endif
          CMD_ROWUP: wptr_d = (wptr_q < ROW_STEP) ? wptr_q + ROW_WRAP : wptr_q - ROW_STEP;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    h_d = h_q + H_CW'(1);
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + V_CW'(1);
    end
    vis     = (h_q < H_VIS_C) && (v_q < V_VIS_C);
    rd_addr = vis ? ADDR_W'(32'(v_q >> SCALE_SH) * FB_W + 32'(h_q >> SCALE_SH)) : '0;
  end

  always_ff @(posedge i_clk) begin
    if (we) mem[waddr] <= wdata;
    rd_q <= mem[rd_addr];
  end

  always_comb begin
    pix = rd_q;
`ifdef TEST_PATTERN_EN
    if (pat_q) pix = {{COL_W{bars1_q[2]}}, {COL_W{bars1_q[1]}}, {COL_W{bars1_q[0]}}};
`endif
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wptr_q     <= '0;
      clr_q      <= 1'b0;
      clr_addr_q <= '0;
      h_q        <= '0;
      v_q        <= '0;
      hs1_q      <= 1'b0;
      vs1_q      <= 1'b0;
      vis1_q     <= 1'b0;
      o_hs       <= 1'b1;
      o_vs       <= 1'b1;
      o_r        <= '0;
      o_g        <= '0;
      o_b        <= '0;
`ifdef TEST_PATTERN_EN
      pat_q      <= 1'b0;
      bars1_q    <= '0;
`endif
    end else begin
      wptr_q     <= wptr_d;
      clr_q      <= clr_d;
      clr_addr_q <= clr_addr_d;
      h_q        <= h_d;
      v_q        <= v_d;
      // Stage 1 lines up with the RAM read, stage 2 drives the pins.
      hs1_q      <= (h_q >= HS_BEG) && (h_q < HS_END);
      vs1_q      <= (v_q >= VS_BEG) && (v_q < VS_END);
      vis1_q     <= vis;
      o_hs       <= ~hs1_q;
      o_vs       <= ~vs1_q;
      o_r        <= vis1_q ? COL_W'(pix_field(7'(pix), COL_W, 2)) : '0;
      o_g        <= vis1_q ? COL_W'(pix_field(7'(pix), COL_W, 1)) : '0;
      o_b        <= vis1_q ? COL_W'(pix_field(7'(pix), COL_W, 0)) : '0;
`ifdef TEST_PATTERN_EN
      pat_q      <= pat_d;
      bars1_q    <= h_q[SCALE_SH+2:SCALE_SH];
`endif
    end
  end

endmodule
